// File: rtl/hitreg_pkg.sv
// Shared field layout and helpers for the fitter hit-input stage.
package hitreg_pkg;

    localparam int ID_LO    = 18;
    localparam int ID_W     = 3;
    localparam int Z_LO     = 15;
    localparam int SIGN_BIT = 14;
    localparam int HIT_W    = 14;
    localparam int C_SIGN   = 18;
    localparam int C_LO     = 12;
    localparam int C_W      = 6;
    localparam int PHI_W    = 12;

    localparam logic [2:0] TRK_ID_DEF = 3'd5;

    typedef enum logic {
        IDLE,
        PAYLOAD
    } trk_phase_t;

    // Magnitude gets an implied LSB of 1 so a track c can never be zero.
    function automatic logic [7:0] twocomp_sm(input logic sign, input logic [5:0] mag);
        logic [7:0] v;
        v = {1'b0, mag, 1'b1};
        return sign ? (~v + 8'd1) : v;
    endfunction

endpackage

// File: rtl/layer_hitmem.sv
// One per-layer hit buffer with its own odometer digit (read pointer).
module layer_hitmem
    import hitreg_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 19
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wr,
    input  logic [W-1:0]               wdata,
    input  logic                       adv,
    output logic [W-1:0]               rdata,
    output logic                       last,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rdptr;
    logic          full;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign last  = empty | ({1'b0, rdptr} == (count - ONE));
    assign rdata = empty ? '0 : mem[rdptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= '0;
            rdptr    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            rdptr    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) begin
                if (full) overflow <= 1'b1;
                else      count    <= count + ONE;
            end
            // An empty or exhausted digit wraps and hands the carry upward.
            if (adv) rdptr <= last ? '0 : rdptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr && !full && !clear) mem[count[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/hit_layer_combiner.sv
// Demultiplexes event words into layer/track buffers and steps through
// every hit combination odometer-style.
module hit_layer_combiner
    import hitreg_pkg::*;
#(
    parameter int               NLAYERS = 5,
    parameter int               DEPTH   = 8,
    parameter int               DW      = 16,
    parameter int               ZW      = 3,
    parameter logic [2:0]       TRK_ID  = TRK_ID_DEF,
    parameter logic [NLAYERS-1:0] ZMASK = 5'b11011
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       clear,
    input  logic                                       we,
    input  logic [22:0]                                din,
    input  logic [11:0]                                phioffset,
    input  logic                                       gnext,
    output logic [NLAYERS*DW-1:0]                      hit_out,
    output logic [NLAYERS*ZW-1:0]                      z_out,
    output logic [DW-1:0]                              trk_c,
    output logic [DW-1:0]                              trk_phi,
    output logic [NLAYERS:0]                           empty,
    output logic [NLAYERS:0]                           overflow,
    output logic [(NLAYERS+1)*($clog2(DEPTH)+1)-1:0]   nhits,
    output logic                                       glast,
    output logic                                       trklast,
    output logic                                       out_of_order,
    output logic                                       bad_id
);
    localparam int NB = NLAYERS + 1;
    localparam int CW = $clog2(DEPTH) + 1;

    trk_phase_t     state;
    logic           seen_trk;
    logic [2:0]     id;
    logic           is_sil;
    logic           is_trk;
    logic           idle;
    logic [NB-1:0]  last;
    logic [NB-1:0]  carry;
    logic           all_last;
    logic           sil_last;
    logic [7:0]     c8;
    logic [12:0]    phi13;
    logic [2*DW-1:0] trk_word;
    logic           unused_din;

    assign id     = din[ID_LO +: ID_W];
    assign is_sil = id < 3'(NLAYERS);
    assign is_trk = id == TRK_ID;
    assign idle   = state == IDLE;

    assign unused_din = ^din[22:21];

    assign c8       = twocomp_sm(din[C_SIGN], din[C_LO +: C_W]);
    assign phi13    = {1'b0, din[PHI_W-1:0]} - {1'b0, phioffset};
    assign trk_word = {{(DW-8){c8[7]}}, c8, {(DW-13){phi13[12]}}, phi13};

    assign carry[0] = gnext;
    assign all_last = &last;
    assign sil_last = &last[NLAYERS-1:0];

    for (genvar k = 0; k < NB; k++) begin : g_buf
        if (k < NB - 1) begin : g_carry
            assign carry[k+1] = carry[k] & last[k];
        end
        if (k < NLAYERS) begin : g_sil
            logic [DW+ZW-1:0] wdata;
            logic [DW+ZW-1:0] rdata;
            assign wdata = {din[SIGN_BIT], {(DW-HIT_W-1){1'b0}},
                            din[HIT_W-1:0],
                            ZMASK[k] ? din[Z_LO +: ZW] : {ZW{1'b0}}};
            layer_hitmem #(.DEPTH(DEPTH), .W(DW+ZW)) u_mem (
                .clock    (clock),
                .reset    (reset),
                .clear    (clear),
                .wr       (we & idle & is_sil & (id == 3'(k))),
                .wdata    (wdata),
                .adv      (carry[k]),
                .rdata    (rdata),
                .last     (last[k]),
                .empty    (empty[k]),
                .count    (nhits[k*CW +: CW]),
                .overflow (overflow[k])
            );
            assign hit_out[k*DW +: DW] = rdata[ZW +: DW];
            assign z_out[k*ZW +: ZW]   = rdata[ZW-1:0];
        end else begin : g_trk
            logic [2*DW-1:0] rdata;
            layer_hitmem #(.DEPTH(DEPTH), .W(2*DW)) u_mem (
                .clock    (clock),
                .reset    (reset),
                .clear    (clear),
                .wr       (we & ~idle),
                .wdata    (trk_word),
                .adv      (carry[k]),
                .rdata    (rdata),
                .last     (last[k]),
                .empty    (empty[k]),
                .count    (nhits[k*CW +: CW]),
                .overflow (overflow[k])
            );
            assign trk_c   = rdata[DW +: DW];
            assign trk_phi = rdata[DW-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            seen_trk     <= 1'b0;
            glast        <= 1'b0;
            trklast      <= 1'b0;
            out_of_order <= 1'b0;
            bad_id       <= 1'b0;
        end else if (clear) begin
            state        <= IDLE;
            seen_trk     <= 1'b0;
            glast        <= 1'b0;
            trklast      <= 1'b0;
            out_of_order <= 1'b0;
            bad_id       <= 1'b0;
        end else begin
            out_of_order <= we & idle & is_sil & seen_trk;
            bad_id       <= we & idle & ~is_sil & ~is_trk;
            if (gnext & all_last) glast   <= 1'b1;
            if (gnext & sil_last) trklast <= 1'b1;
            // The word after a header is payload, whatever its ID bits say.
            unique case (state)
                IDLE: begin
                    if (we & is_trk) begin
                        state    <= PAYLOAD;
                        seen_trk <= 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (we) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
